if_stage: RTL
=============

Name: if_stage

Overview:
- Pre-IF and IF pipeline stage of the 5-stage LoongArch core; sits directly upstream of the decode (ID) stage.
- Generates the next PC and drives the synchronous inst SRAM read port.
- Holds the fetched PC/instruction in the IF register and hands it to ID with a valid/allowin handshake.
- Absorbs ID back-pressure with an instruction holding buffer, applies branch redirects from ID, and flags fetch-address misalignment (ADEF).

Parameters:
- RESET_PC, 32'h1c000000, address of the first fetch after reset.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- inst_sram_en  out  1  read request this cycle
- inst_sram_we  out  4  constant 4'b0
- inst_sram_addr  out  32  fetch address, equal to nextpc
- inst_sram_wdata  out  32  constant 32'b0
- inst_sram_rdata  in  32  read data, valid exactly 1 cycle after an accepted request
- id_allowin  in  1  ID can accept an instruction this cycle
- br_taken  in  1  ID redirect, qualified by ID valid/ready in ID
- br_target  in  32  redirect address
- if_to_id_valid  out  1  IF holds a deliverable instruction
- if_to_id_pc  out  32  PC of that instruction
- if_to_id_inst  out  32  instruction word (0 when ADEF)
- if_to_id_adef  out  1  PC[1:0] != 0; instruction not fetched

Behaviour:
- Registers: if_valid, if_pc, if_adef, inst_buf[31:0], inst_buf_valid.
- Reset values: if_valid=0, if_pc=RESET_PC-4, if_adef=0, inst_buf_valid=0, inst_buf=0.
- Outputs during reset: inst_sram_en=0, inst_sram_addr=RESET_PC, if_to_id_valid=0.
- seq_pc = if_pc + 4 (32-bit, wraps modulo 2^32).
- nextpc = br_taken ? br_target : seq_pc.
- if_ready_go = 1.
- if_allowin = !if_valid || (id_allowin && !br_taken) || br_taken. This means br_taken forces allowin.
- inst_sram_en = !reset && if_allowin && (nextpc[1:0]==0). A misaligned nextpc issues no SRAM request.
- Update on an if_allowin cycle (not in reset):
  - if_valid <= 1
  - if_pc <= nextpc
  - if_adef <= (nextpc[1:0]!=0)
  - inst_buf_valid <= 0
- if_to_id_valid = if_valid && !br_taken. A redirect kills the instruction currently in IF, so it never reaches ID.
- if_to_id_inst:
  - 0 if if_adef;
  - else inst_buf if inst_buf_valid;
  - else inst_sram_rdata.
- if_to_id_pc = if_pc; if_to_id_adef = if_adef.
- Buffer capture: if if_valid && !if_adef && !inst_buf_valid && !id_allowin && !br_taken, then inst_buf <= inst_sram_rdata and inst_buf_valid <= 1.
  - Capture happens in the first cycle of a stall, the only cycle rdata is valid.
  - Held until IF advances.
- Stall: while id_allowin=0 and no br_taken, if_pc, if_valid and the buffer hold, and inst_sram_en=0 (no new request).
- Simultaneous id_allowin=0 and br_taken=1: the redirect wins. The IF instruction is dropped, the request to br_target is issued, and the buffer is cleared.
- br_taken with if_valid=0: redirect still taken (if_pc <= br_target).
- Latency: request at cycle t → if_to_id_valid at t+1 with rdata combinationally forwarded. Back-to-back throughput is 1 instruction/cycle.
- ADEF: an IF entry is created at the misaligned PC without an SRAM access. Following fetches continue at PC+4 (same misalignment) unless redirected; ID/exception logic owns recovery.
- Reset mid-stall or mid-redirect: all state returns to reset values next edge, and any in-flight rdata is ignored.

Test Plan:
- Release reset, id_allowin=1 constantly → inst_sram_addr 0x1c000000, 0x1c000004, 0x1c000008 on consecutive cycles. if_to_id_pc follows one cycle later with the SRAM words; 1 instr/cycle.
- Stall: PC 0x1c000008 in IF with rdata 0x02800421, then id_allowin=0 for 3 cycles while the SRAM returns garbage.
  - Expect inst_sram_en=0 during the stall and if_to_id_inst=0x02800421 held throughout.
  - On release, next addr is 0x1c00000c.
- Redirect: br_taken=1 with br_target=0x1c000100 while IF holds 0x1c000010.
  - Expect if_to_id_valid=0 that cycle and inst_sram_addr=0x1c000100 with en=1.
  - Next cycle if_to_id_pc=0x1c000100.
- Redirect during stall: id_allowin=0 with buffer full, then br_taken to 0x1c000200.
  - Expect the buffer to be discarded and the next delivered PC to be 0x1c000200 with its new rdata.
- Misaligned target: br_target=0x1c000302 → inst_sram_en=0. Next cycle if_to_id_valid=1, adef=1, inst=0, pc=0x1c000302.
- Reset asserted mid-stall → next cycle if_to_id_valid=0, inst_sram_en=0. After release, the first fetch is 0x1c000000.

Source files
------------

// File: rtl/if_stage.sv
// Pre-IF / IF stage: next-PC generation, inst SRAM request, IF register and
// a one-entry holding buffer that keeps the fetched word alive across ID stalls.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,

    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata,

    input  logic        id_allowin,
    input  logic        br_taken,
    input  logic [31:0] br_target,

    output logic        if_to_id_valid,
    output logic [31:0] if_to_id_pc,
    output logic [31:0] if_to_id_inst,
    output logic        if_to_id_adef
);

    logic        if_valid;
    logic [31:0] if_pc;
    logic        if_adef;
    logic [31:0] inst_buf;
    logic        inst_buf_valid;

    logic [31:0] seq_pc;
    logic [31:0] nextpc;
    logic        nextpc_misaligned;
    logic        if_ready_go;
    logic        if_allowin;
    logic        buf_capture;

    assign seq_pc            = if_pc + 32'd4;
    assign nextpc            = br_taken ? br_target : seq_pc;
    assign nextpc_misaligned = (nextpc[1:0] != 2'b00);
    assign if_ready_go       = 1'b1;

    // A redirect always opens IF: the current instruction is killed anyway.
    assign if_allowin = !if_valid || (if_ready_go && id_allowin && !br_taken) || br_taken;

    // rdata is only valid in the first cycle after a request, so the first
    // stalled cycle is the only chance to keep it.
    assign buf_capture = if_valid && !if_adef && !inst_buf_valid && !id_allowin && !br_taken;

    assign inst_sram_en    = !reset && if_allowin && !nextpc_misaligned;
    assign inst_sram_we    = 4'b0000;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_wdata = 32'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            if_valid       <= 1'b0;
            if_pc          <= RESET_PC - 32'd4;
            if_adef        <= 1'b0;
            inst_buf       <= 32'b0;
            inst_buf_valid <= 1'b0;
        end else if (if_allowin) begin
            if_valid       <= 1'b1;
            if_pc          <= nextpc;
            if_adef        <= nextpc_misaligned;
            inst_buf_valid <= 1'b0;
        end else if (buf_capture) begin
            inst_buf       <= inst_sram_rdata;
            inst_buf_valid <= 1'b1;
        end
    end

    always_comb begin
        if_to_id_inst = inst_sram_rdata;
        if (if_adef) begin
            if_to_id_inst = 32'b0;
        end else if (inst_buf_valid) begin
            if_to_id_inst = inst_buf;
        end
    end

    assign if_to_id_valid = if_valid && if_ready_go && !br_taken;
    assign if_to_id_pc    = if_pc;
    assign if_to_id_adef  = if_adef;

endmodule
